ser_frame_ctrl: RTL

//  Frame-sync controller for the serial receive path. Hunts a fixed sync word in
//  the 1-bit din stream, then sequences payload capture: assembles nibbles (MSB

---
 rtl/ser_frame_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ser_frame_ctrl.sv
// ser_frame_ctrl: serial frame-sync controller. Hunts a sync word, captures MSB-first
// payload nibbles with even parity, and keeps lock through a flywheel on sync misses.
`default_nettype none

module ser_frame_ctrl #(
  parameter int unsigned          SYNC_W   = 5,
  parameter logic [SYNC_W-1:0]    SYNC_PAT = 5'b10100,
  parameter int unsigned          NIB_CNT  = 2,
  parameter int unsigned          MISS_MAX = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       din,
  output logic [3:0] dout,
  output logic       strobe,
  output logic       frame_start,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       sync_lost,
  output logic       locked
);

  localparam int unsigned PAY_BITS = NIB_CNT * 4;
  localparam int unsigned CNT_A    = $clog2(PAY_BITS + 1);
  localparam int unsigned CNT_B    = $clog2(SYNC_W + 1);
  // The same counter also paces the sync check, so it must hold SYNC_W-1 too.
  localparam int unsigned CNT_W    = (CNT_A > CNT_B) ? CNT_A : CNT_B;

  localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(PAY_BITS);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [2:0]       MISS_LIM  = 3'(MISS_MAX);

  localparam logic [1:0] HUNT     = 2'd0;
  localparam logic [1:0] PAYLOAD  = 2'd1;
  localparam logic [1:0] PARITY   = 2'd2;
  localparam logic [1:0] SYNC_CHK = 2'd3;

  logic [1:0]        state;
  logic [SYNC_W-2:0] sr;
  logic [CNT_W-1:0]  bit_cnt;
  logic [2:0]        miss_cnt;
  logic [2:0]        nib;
  logic              par;

  logic [SYNC_W-1:0] win;
  logic [CNT_W-1:0]  bit_nxt;
  logic [2:0]        miss_nxt;

  assign win      = {sr, din};
  assign bit_nxt  = bit_cnt + CNT_W'(1);
  assign miss_nxt = miss_cnt + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      sr          <= '0;
      bit_cnt     <= '0;
      miss_cnt    <= '0;
      nib         <= '0;
      par         <= 1'b0;
      dout        <= '0;
      strobe      <= 1'b0;
      frame_start <= 1'b0;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
      sync_lost   <= 1'b0;
      locked      <= 1'b0;
    end else begin
      strobe      <= 1'b0;
      frame_start <= 1'b0;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
      sync_lost   <= 1'b0;
      if (en) begin
        sr <= win[SYNC_W-2:0];
        case (state)
          HUNT: begin
            if (win == SYNC_PAT) begin
              state       <= PAYLOAD;
              bit_cnt     <= '0;
              par         <= 1'b0;
              miss_cnt    <= '0;
              frame_start <= 1'b1;
              locked      <= 1'b1;
            end
          end
          PAYLOAD: begin
            nib     <= {nib[1:0], din};
            par     <= par ^ din;
            bit_cnt <= bit_nxt;
            if (bit_nxt[1:0] == 2'b00) begin
              dout   <= {nib, din};
              strobe <= 1'b1;
            end
            if (bit_nxt == PAY_LAST) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            if (par ^ din) begin
              frame_err <= 1'b1;
            end else begin
              frame_ok <= 1'b1;
            end
            state   <= SYNC_CHK;
            bit_cnt <= '0;
          end
          SYNC_CHK: begin
            bit_cnt <= bit_nxt;
            if (bit_cnt == SYNC_LAST) begin
              bit_cnt <= '0;
              par     <= 1'b0;
              if (win == SYNC_PAT) begin
                miss_cnt    <= '0;
                state       <= PAYLOAD;
                frame_start <= 1'b1;
              end else if (miss_nxt < MISS_LIM) begin
                // Flywheel: tolerate an isolated bad sync word and keep framing.
                miss_cnt    <= miss_nxt;
                state       <= PAYLOAD;
                frame_start <= 1'b1;
              end else begin
                miss_cnt  <= '0;
                state     <= HUNT;
                sync_lost <= 1'b1;
                locked    <= 1'b0;
              end
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
